// File: rtl/apb4_host_bridge_if.sv
// apb4_intf: APB4 bus bundle with host and agent views.
interface apb4_intf #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32
);
    logic [AWIDTH-1:0]   paddr;
    logic                psel;
    logic                penable;
    logic                pwrite;
    logic [DWIDTH-1:0]   pwdata;
    logic [DWIDTH/8-1:0] pstrb;
    logic [2:0]          pprot;
    logic [DWIDTH-1:0]   prdata;
    logic                pready;
    logic                pslverr;
    modport host (output paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
                  input  prdata, pready, pslverr);
    modport agent (input  paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
                   output prdata, pready, pslverr);
endinterface

// File: rtl/apb4_host_bridge.sv
// apb4_host_bridge: turns a valid/ready command stream into single APB4 host
// transfers, with a PREADY timeout, and returns completions on a response stream.
module apb4_host_bridge #(
    parameter int DWIDTH  = 32,
    parameter int AWIDTH  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [AWIDTH-1:0]   cmd_addr,
    input  logic [DWIDTH-1:0]   cmd_wdata,
    input  logic [DWIDTH/8-1:0] cmd_strb,
    input  logic [2:0]          cmd_prot,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DWIDTH-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_timeout,
    apb4_intf.host              apb
);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    assign cmd_ready = state == IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            apb.psel    <= 1'b0;
            apb.penable <= 1'b0;
            apb.pwrite  <= 1'b0;
            apb.paddr   <= '0;
            apb.pwdata  <= '0;
            apb.pstrb   <= '0;
            apb.pprot   <= '0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    apb.paddr  <= cmd_addr;
                    apb.pwrite <= cmd_write;
                    apb.pwdata <= cmd_write ? cmd_wdata : '0;
                    apb.pstrb  <= cmd_write ? cmd_strb : '0;
                    apb.pprot  <= cmd_prot;
                    apb.psel   <= 1'b1;
                    state      <= SETUP;
                end
                SETUP: begin
                    apb.penable <= 1'b1;
                    cnt         <= '0;
                    state       <= ACCESS;
                end
                ACCESS: if (apb.pready) begin
                    rsp_rdata   <= apb.pwrite ? '0 : apb.prdata;
                    rsp_err     <= apb.pslverr;
                    rsp_timeout <= 1'b0;
                    rsp_valid   <= 1'b1;
                    apb.psel    <= 1'b0;
                    apb.penable <= 1'b0;
                    state       <= RESP;
                end else if (TIMEOUT > 0 && cnt == LAST) begin
                    // agent never answered: abort so the stream cannot stall
                    rsp_rdata   <= '0;
                    rsp_err     <= 1'b1;
                    rsp_timeout <= 1'b1;
                    rsp_valid   <= 1'b1;
                    apb.psel    <= 1'b0;
                    apb.penable <= 1'b0;
                    state       <= RESP;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb4_host_bridge.sv
// tb_apb4_host_bridge: table vectors, hand-written reset sequences and random
// transactions checked against a rule-level model of the bridge.
module tb_apb4_host_bridge;
    localparam int TO = 8;

    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int          waits;
        logic [31:0] rdata;
        logic        slverr;
        int          delay;
        logic        hold;
        logic [31:0] er;
        logic        ee;
        logic        et;
        int          eacc;
    } vec_t;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        cmd_valid = 0, cmd_write = 0, rsp_ready = 0;
    logic [31:0] cmd_addr = 0, cmd_wdata = 0;
    logic [3:0]  cmd_strb = 0;
    logic [2:0]  cmd_prot = 0;
    logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    int          checks = 0, failures = 0;

    apb4_intf #(.DWIDTH(32), .AWIDTH(32)) bus ();

    apb4_host_bridge #(.DWIDTH(32), .AWIDTH(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .apb(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // expected outcome derived only from the transaction's rules
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        logic to = v.waits >= TO;
        r.et   = to;
        r.ee   = to | v.slverr;
        r.er   = (to || v.w) ? 32'h0 : v.rdata;
        r.eacc = to ? TO : v.waits + 1;
        return r;
    endfunction

    task automatic drive_cmd(input vec_t v);
        cmd_valid = 1; cmd_write = v.w; cmd_addr = v.addr;
        cmd_wdata = v.wdata; cmd_strb = v.strb; cmd_prot = v.prot;
    endtask

    task automatic run_txn(input string tag, input vec_t v);
        int nset = 0, nacc = 0, busbad = 0, g = 0, holdbad = 0;
        logic [31:0] xw  = v.w ? v.wdata : 32'h0;
        logic [3:0]  xs  = v.w ? v.strb : 4'h0;
        logic [34:0] snap;
        drive_cmd(v);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = v.hold;
        while (!rsp_valid && g < 40) begin
            if (bus.psel && (bus.paddr !== v.addr || bus.pwrite !== v.w || bus.pwdata !== xw
                             || bus.pstrb !== xs || bus.pprot !== v.prot)) busbad++;
            if (cmd_ready) busbad++;
            if (bus.psel && !bus.penable) nset++;
            else if (bus.psel && bus.penable) begin
                bus.pready  = nacc == v.waits;
                bus.prdata  = nacc == v.waits ? v.rdata : $urandom;
                bus.pslverr = nacc == v.waits ? v.slverr : 1'($urandom);
                nacc++;
            end else busbad++;
            @(posedge clk); #1;
            bus.pready = 0; bus.pslverr = 0;
            g++;
        end
        chk({tag, "_bounded"}, g < 40, 1);
        chk({tag, "_setup_cycles"}, nset, 1);
        chk({tag, "_access_cycles"}, nacc, v.eacc);
        chk({tag, "_bus_fields"}, busbad, 0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, v.er);
        chk({tag, "_rsp_err_to"}, {rsp_err, rsp_timeout}, {v.ee, v.et});
        chk({tag, "_bus_idle_in_resp"}, {bus.psel, bus.penable}, 0);
        snap = {rsp_rdata, rsp_err, rsp_timeout, rsp_valid};
        for (int i = 0; i < v.delay; i++) begin
            @(posedge clk); #1;
            if ({rsp_rdata, rsp_err, rsp_timeout, rsp_valid} !== snap || cmd_ready || bus.psel) holdbad++;
        end
        chk({tag, "_resp_hold"}, holdbad, 0);
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        chk({tag, "_after_handshake"}, {rsp_valid, cmd_ready, bus.psel}, 3'b010);
        cmd_valid = 0;
    endtask

    vec_t tbl[7];
    vec_t v;

    initial begin
        bus.pready = 0; bus.pslverr = 0; bus.prdata = 0;
        //          w  addr   wdata         strb prot waits rdata         se dly hold er           ee et acc
        tbl[0] = '{1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b010, 0,  32'h0,        0, 0, 0, 32'h0,        0, 0, 1};
        tbl[1] = '{0, 32'h20, 32'hFFFFFFFF, 4'hF, 3'b000, 3,  32'h12345678, 0, 0, 0, 32'h12345678, 0, 0, 4};
        tbl[2] = '{1, 32'h44, 32'h0BADF00D, 4'h3, 3'b001, 1,  32'h99999999, 1, 0, 0, 32'h0,        1, 0, 2};
        tbl[3] = '{0, 32'h80, 32'h0,        4'h0, 3'b100, 99, 32'hAAAA5555, 0, 0, 0, 32'h0,        1, 1, 8};
        tbl[4] = '{0, 32'h84, 32'h0,        4'h0, 3'b011, 7,  32'h00000055, 0, 0, 0, 32'h00000055, 0, 0, 8};
        tbl[5] = '{0, 32'hC0, 32'h11111111, 4'hF, 3'b111, 0,  32'h0000CAFE, 0, 5, 1, 32'h0000CAFE, 0, 0, 1};
        tbl[6] = '{0, 32'hC4, 32'h0,        4'h0, 3'b000, 2,  32'h00000077, 1, 1, 0, 32'h00000077, 1, 0, 3};

        #12;
        chk("reset_bus", {bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata, bus.pstrb, bus.pprot}, 0);
        chk("reset_rsp", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout}, 0);
        chk("reset_cmd_ready", cmd_ready, 1);
        @(posedge clk); #1 rst_n = 1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) run_txn($sformatf("vec%0d", i), tbl[i]);

        // reset pulse during ACCESS
        v = tbl[3];
        drive_cmd(v);
        @(posedge clk); #1 cmd_valid = 0;
        @(posedge clk); #1;
        chk("rst_mid_access_entered", {bus.psel, bus.penable}, 2'b11);
        #2 rst_n = 0;
        #1;
        chk("rst_async_drop", {bus.psel, bus.penable, rsp_valid}, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        @(posedge clk); #1 rst_n = 1;
        @(posedge clk); #1;
        chk("rst_no_response", rsp_valid, 0);
        run_txn("post_rst", tbl[0]);

        // reset pulse while a response is pending
        v = tbl[1];
        v.waits = 0;
        drive_cmd(v);
        @(posedge clk); #1 cmd_valid = 0;
        bus.pready = 0;
        @(posedge clk); #1 bus.pready = 1; bus.prdata = 32'h1;
        @(posedge clk); #1 bus.pready = 0;
        chk("rst_resp_entered", rsp_valid, 1);
        #2 rst_n = 0;
        #1;
        chk("rst_resp_drop", {rsp_valid, rsp_rdata, rsp_err}, 0);
        @(posedge clk); #1 rst_n = 1;
        @(posedge clk); #1;

        for (int i = 0; i < 30; i++) begin
            v.w      = 1'($urandom);
            v.addr   = $urandom & 32'hFFFF_FFFC;
            v.wdata  = $urandom;
            v.strb   = 4'($urandom);
            v.prot   = 3'($urandom);
            v.waits  = $urandom_range(0, 10);
            v.rdata  = $urandom;
            v.slverr = 1'($urandom);
            v.delay  = $urandom_range(0, 3);
            v.hold   = 1'($urandom);
            run_txn($sformatf("rnd%0d", i), model(v));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
